// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a single-port word memory; sub-word stores become read-modify-write.
// Accepts one request in IDLE only and holds the memory bus steady until mem_ready.
module memstager (
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);
  logic [31:0] shifted;
  logic [4:0]  sh;

  always_comb begin
    sh        = {offset, 3'b000};
    shifted   = word >> sh;
    load_data = 32'h0;
    case (funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase

    store_data = wdata;
    case (funct3[1:0])
      2'b00:   store_data = (word & ~(32'h0000_00FF << sh)) | ({24'h0, wdata[7:0]} << sh);
      2'b01:   store_data = (word & ~(32'h0000_FFFF << sh)) | ({16'h0, wdata[15:0]} << sh);
      default: store_data = wdata;
    endcase
  end
endmodule

module mem_access_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic [31:0] stage_word;
  logic [31:0] load_data;
  logic [31:0] store_data;

  // In RD the word being captured is fed straight through so the load result registers on the same edge.
  assign stage_word = (state_q == S_RD) ? mem_rdata : word_q;

  memstager u_stager (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .word       (stage_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      if (req_funct3 > 3'b010) req_err = 1'b1;
    end else if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) begin
      req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    word_d   = word_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'h0;
          err_d    = req_err;
          if (req_err)                              state_d = S_RESP;
          else if (req_we && req_funct3 == 3'b010)  state_d = S_WR;
          else                                      state_d = S_RD;
        end
      end
      S_RD: begin
        if (mem_ready) begin
          word_d = mem_rdata;
          if (we_q) begin
            state_d = S_WR;
          end else begin
            rdata_d = load_data;
            state_d = S_RESP;
          end
        end
      end
      S_WR: begin
        if (mem_ready) state_d = S_RESP;
      end
      default: begin
        rdata_d = 32'h0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      word_q   <= word_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus outputs derive only from state and latched request, so reset clears them without a clock.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_valid  = (state_q == S_RD) || (state_q == S_WR);
  assign mem_we     = (state_q == S_WR);
  assign mem_addr   = mem_valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata  = mem_we ? store_data : 32'h0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a wait-state memory model.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  mem_access_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
    string       tag;
  } exp_t;

  exp_t sb[$];
  bit [31:0] mem [bit [31:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  int          wait_rd = 0, wait_wr = 0, wcnt = 0;
  int          mv_cycles = 0, rd_cycles = 0;
  logic [31:0] p_addr, p_wdata, last_rd_addr, last_wr_addr, last_wr_data;
  logic        p_we;
  bit          p_wait = 0;

  always @(negedge clk) begin
    if (!resetn) begin
      wcnt = 0; p_wait = 0; mem_ready = 1'b0;
    end else if (mem_valid) begin
      mv_cycles++;
      if (!mem_we) rd_cycles++;
      if (p_wait) begin
        check("bus_addr_stable", mem_addr, p_addr);
        check("bus_we_stable", {31'h0, mem_we}, {31'h0, p_we});
        check("bus_wdata_stable", mem_wdata, p_wdata);
      end
      if (wcnt < (mem_we ? wait_wr : wait_rd)) begin
        wcnt++;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        p_wait = 1; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      end else begin
        wcnt = 0; p_wait = 0;
        mem_ready = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          last_wr_addr = mem_addr; last_wr_data = mem_wdata;
        end else begin
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
          last_rd_addr = mem_addr;
        end
      end
    end else begin
      wcnt = 0; p_wait = 0;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  // ---------------- response monitor ----------------
  logic [31:0] last_rdata;
  always @(negedge clk) begin
    if (resetn && resp_valid) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", {31'h0, resp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        last_rdata = resp_rdata;
        check({e.tag, "_err"}, {31'h0, resp_err}, {31'h0, e.err});
        check({e.tag, "_rdata"}, resp_rdata, e.rdata);
        check({e.tag, "_latency"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_err(bit we, bit [2:0] f3, bit [31:0] a);
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) return 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] model_load(bit [2:0] f3, bit [1:0] off, bit [31:0] w);
    bit [7:0]  b;
    bit [15:0] h;
    b = w[8*off +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return w;
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit [31:0] model_store(bit [2:0] f3, bit [1:0] off, bit [31:0] w, bit [31:0] wd);
    bit [31:0] r;
    r = w;
    case (f3)
      3'b000: r[8*off +: 8] = wd[7:0];
      3'b001: if (off[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input int wr_w, input int ww_w, input string tag);
    bit        err;
    bit [31:0] wa, word, exp_rd, exp_word;
    int        lat, n, mv0, rd0;
    wa       = {a[31:2], 2'b00};
    word     = mem.exists(wa) ? mem[wa] : 32'h0;
    err      = model_err(we, f3, a);
    exp_rd   = (err || we) ? 32'h0 : model_load(f3, a[1:0], word);
    exp_word = (err || !we) ? word : model_store(f3, a[1:0], word, wd);
    if (err)              lat = 1;
    else if (!we)         lat = 2 + wr_w;
    else if (f3 == 3'd2)  lat = 2 + ww_w;
    else                  lat = 3 + wr_w + ww_w;
    wait_rd = wr_w; wait_wr = ww_w;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mv0 = mv_cycles; rd0 = rd_cycles;
    sb.push_back('{err, exp_rd, cyc + lat, tag});
    @(negedge clk);
    // Scramble the request lines after accept: the controller must use latched values.
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(sb.size()), 32'h0);
    if (err) check({tag, "_no_mem"}, 32'(mv_cycles - mv0), 32'h0);
    if (we && !err && f3 == 3'd2) check({tag, "_no_read"}, 32'(rd_cycles - rd0), 32'h0);
    check({tag, "_memword"}, mem.exists(wa) ? mem[wa] : 32'h0, exp_word);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); resetn = 1'b1;

    mem[32'h100] = 32'hDEADBEEF;
    do_req(0, 3'b010, 32'h100, 32'h0, 0, 0, "LW");
    check("LW_value", last_rdata, 32'hDEADBEEF);
    check("LW_addr", last_rd_addr, 32'h100);

    mem[32'h200] = 32'h80FF7F01;
    do_req(0, 3'b000, 32'h203, 32'h0, 0, 0, "LB");
    check("LB_value", last_rdata, 32'hFFFFFF80);
    do_req(0, 3'b100, 32'h203, 32'h0, 1, 0, "LBU");
    check("LBU_value", last_rdata, 32'h00000080);
    do_req(0, 3'b001, 32'h202, 32'h0, 0, 0, "LH");
    check("LH_value", last_rdata, 32'hFFFF80FF);

    mem[32'h300] = 32'h11223344;
    do_req(1, 3'b000, 32'h301, 32'h000000AB, 2, 0, "SB");
    check("SB_wdata", last_wr_data, 32'h1122AB44);
    check("SB_waddr", last_wr_addr, 32'h300);

    do_req(1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0, "SW");
    check("SW_wdata", last_wr_data, 32'hCAFEF00D);

    do_req(1, 3'b001, 32'h302, 32'h0000BEEF, 0, 2, "SH");
    check("SH_wdata", last_wr_data, 32'hBEEFAB44);

    do_req(0, 3'b010, 32'h102, 32'h0, 0, 0, "LW_misaligned");
    do_req(1, 3'b001, 32'h001, 32'h0, 0, 0, "SH_misaligned");
    do_req(0, 3'b011, 32'h100, 32'h0, 0, 0, "LD_illegal");
    do_req(1, 3'b100, 32'h100, 32'h0, 0, 0, "ST_illegal");

    for (int i = 0; i < 24; i++) begin
      bit [31:0] a;
      a = 32'h600 + 32'($urandom_range(0, 31));
      if (!mem.exists({a[31:2], 2'b00})) mem[{a[31:2], 2'b00}] = $urandom;
      do_req(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), "RND");
    end

    // Reset while a read-modify-write is stalled in its write phase.
    mem[32'h500] = 32'h55667788;
    wait_rd = 0; wait_wr = 1000;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h502; req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(mem_valid && mem_we) && n < 20) begin @(negedge clk); n++; end
    check("RST_in_wr", {31'h0, mem_we}, 32'h1);
    #2 resetn = 1'b0;
    #1;
    check("RST_mem_valid", {31'h0, mem_valid}, 32'h0);
    check("RST_mem_we", {31'h0, mem_we}, 32'h0);
    check("RST_mem_addr", mem_addr, 32'h0);
    check("RST_mem_wdata", mem_wdata, 32'h0);
    check("RST_req_ready", {31'h0, req_ready}, 32'h1);
    check("RST_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("RST_resp_rdata", resp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    check("RST_mem_untouched", mem[32'h500], 32'h55667788);
    resetn = 1'b1;
    wait_wr = 0;
    do_req(0, 3'b010, 32'h100, 32'h0, 0, 0, "LW_after_rst");
    check("LW_after_rst_value", last_rdata, 32'hDEADBEEF);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
